// File: rtl/nmt_host_request_issuer.sv
// Host request FIFO feeding the NMT core: issues held accesses,
// release pulses, and context-switch pulses on thread-address collision.
module nmt_host_request_issuer #(
  parameter int ADDR_W        = 9,
  parameter int THREAD_ADDR_W = 32,
  parameter int DEPTH         = 8,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic                        req_write,
  input  logic                        req_release,
  input  logic                        nmt_active,
  input  logic [THREAD_ADDR_W-1:0]    nmt_thread_address,
  output logic [ADDR_W-1:0]           used_address,
  output logic                        read_or_write,
  output logic                        req_active,
  output logic                        freed,
  output logic [ADDR_W-1:0]           freed_address,
  output logic                        context_switch,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SWITCH, ISSUE, RELEASE} state_t;

  logic [ADDR_W+1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              cur_write_q, cur_write_d;
  logic [ADDR_W-1:0] used_q, used_d;
  logic              rw_q, rw_d;
  logic              active_q, active_d;
  logic              freed_q, freed_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic              cs_q, cs_d;

  logic              push, pop, collide;
  logic [ADDR_W-1:0] head_addr;
  logic              head_write, head_rel;

  assign req_ready = (count_q != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign {head_addr, head_write, head_rel} = mem[rptr_q];
  assign collide   = nmt_active &&
                     (nmt_thread_address == THREAD_ADDR_W'(head_addr));

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {req_addr, req_write, req_release};
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Outputs are computed for the next state and registered with it.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cur_addr_d  = cur_addr_q;
    cur_write_d = cur_write_q;
    used_d      = used_q;
    faddr_d     = faddr_q;
    rw_d        = 1'b0;
    active_d    = 1'b0;
    freed_d     = 1'b0;
    cs_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cur_addr_d  = head_addr;
          cur_write_d = head_write;
          if (head_rel) begin
            state_d = RELEASE;
            freed_d = 1'b1;
            faddr_d = head_addr;
          end else if (collide) begin
            state_d = SWITCH;
            cs_d    = 1'b1;
          end else begin
            state_d  = ISSUE;
            active_d = 1'b1;
            used_d   = head_addr;
            rw_d     = head_write;
            hold_d   = HW'(HOLD_CYCLES - 1);
          end
        end
      end
      SWITCH: begin
        state_d  = ISSUE;
        active_d = 1'b1;
        used_d   = cur_addr_q;
        rw_d     = cur_write_q;
        hold_d   = HW'(HOLD_CYCLES - 1);
      end
      ISSUE: begin
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d   = hold_q - 1'b1;
          active_d = 1'b1;
          rw_d     = cur_write_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      cur_addr_q  <= '0;
      cur_write_q <= 1'b0;
      used_q      <= '0;
      rw_q        <= 1'b0;
      active_q    <= 1'b0;
      freed_q     <= 1'b0;
      faddr_q     <= '0;
      cs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      cur_addr_q  <= cur_addr_d;
      cur_write_q <= cur_write_d;
      used_q      <= used_d;
      rw_q        <= rw_d;
      active_q    <= active_d;
      freed_q     <= freed_d;
      faddr_q     <= faddr_d;
      cs_q        <= cs_d;
    end
  end

  assign used_address   = used_q;
  assign read_or_write  = rw_q;
  assign req_active     = active_q;
  assign freed          = freed_q;
  assign freed_address  = faddr_q;
  assign context_switch = cs_q;
  assign fifo_count     = count_q;

endmodule
